// File: rtl/xor_stream_cipher_pkg.sv
// xor_cipher_pkg: shared state encodings, default sizes and key-slice sizing helpers
package xor_cipher_pkg;
    typedef enum logic [1:0] {KEY_EMPTY, KEY_LOADING, KEY_READY} key_state_t;
    typedef enum logic {TX_IDLE, TX_SHIFT} tx_state_t;
    localparam int DEF_MSG_SIZE = 8;
    localparam int DEF_KEY_SIZE = 32;
    function automatic int slice_count(input int key_size, input int msg_size);
        return key_size / msg_size;
    endfunction
    function automatic int idx_width(input int key_size, input int msg_size);
        return (key_size / msg_size > 1) ? $clog2(key_size / msg_size) : 1;
    endfunction
endpackage

// File: rtl/xor_stream_cipher_if.sv
// xor_stream_cipher_if: serial key/message input bundle and ciphertext output bundle
interface xor_stream_cipher_if;
    logic ena;
    logic iData_in;
    logic iKey_flag;
    logic iMsg_flag;
    logic oData_out;
    logic oData_flag;
    logic oKey_valid;
    logic oBusy;
    logic oError;
    modport master (output ena, iData_in, iKey_flag, iMsg_flag,
                    input  oData_out, oData_flag, oKey_valid, oBusy, oError);
    modport slave  (input  ena, iData_in, iKey_flag, iMsg_flag,
                    output oData_out, oData_flag, oKey_valid, oBusy, oError);
endinterface

// File: rtl/xor_stream_cipher_tx_shifter.sv
// cipher_tx_shifter: parallel-load, MSB-first serial-out register with a valid flag
module cipher_tx_shifter import xor_cipher_pkg::*; #(
    parameter int MSG_SIZE = DEF_MSG_SIZE
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_ena,
    input  logic                i_load,
    input  logic [MSG_SIZE-1:0] i_word,
    output logic                o_data,
    output logic                o_flag
);
    localparam int CW = $clog2(MSG_SIZE);
    tx_state_t           r_state;
    logic [MSG_SIZE-1:0] r_sr;
    logic [CW-1:0]       r_cnt;
    // A load on the final bit's edge restarts the word, keeping the flag high for streaming
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= TX_IDLE;
            r_sr    <= '0;
            r_cnt   <= '0;
        end else if (i_ena) begin
            if (i_load) begin
                r_state <= TX_SHIFT;
                r_sr    <= i_word;
                r_cnt   <= '0;
            end else if (r_state == TX_SHIFT) begin
                r_sr  <= r_sr << 1;
                r_cnt <= r_cnt + 1'b1;
                if (r_cnt == CW'(MSG_SIZE - 1)) begin
                    r_state <= TX_IDLE;
                    r_cnt   <= '0;
                end
            end
        end
    end
    assign o_data = r_sr[MSG_SIZE-1];
    assign o_flag = r_state == TX_SHIFT;
endmodule

// File: rtl/xor_stream_cipher.sv
// xor_stream_cipher: serial key load, word assembly, rotating key-slice XOR and serial ciphertext out
module xor_stream_cipher import xor_cipher_pkg::*; #(
    parameter int MSG_SIZE   = DEF_MSG_SIZE,
    parameter int KEY_SIZE   = DEF_KEY_SIZE,
    parameter int KEY_ROTATE = 1
) (
    input logic               clk,
    input logic               rst,
    xor_stream_cipher_if.slave bus
);
    localparam int NSLICE = slice_count(KEY_SIZE, MSG_SIZE);
    localparam int IW     = idx_width(KEY_SIZE, MSG_SIZE);
    localparam int KW     = $clog2(KEY_SIZE);
    localparam int MW     = $clog2(MSG_SIZE);
    if (KEY_SIZE % MSG_SIZE != 0 || MSG_SIZE < 2) begin : g_bad_size
        $error("KEY_SIZE must be a multiple of MSG_SIZE and MSG_SIZE >= 2");
    end
    key_state_t          r_key_state;
    logic [KEY_SIZE-1:0] r_key;
    logic [KW-1:0]       r_key_cnt;
    logic [MSG_SIZE-1:0] r_msg;
    logic [MW-1:0]       r_msg_cnt;
    logic [IW-1:0]       r_idx;
    logic                r_err;
    logic [MSG_SIZE-1:0] w_slices [NSLICE];
    logic [MSG_SIZE-1:0] w_cipher;
    logic                w_msg_bit;
    logic                w_word_done;
    logic                w_flag;
    // First-received key bits form slice 0
    for (genvar g = 0; g < NSLICE; g++) begin : g_slice
        assign w_slices[g] = r_key[KEY_SIZE-1-g*MSG_SIZE -: MSG_SIZE];
    end
    assign w_msg_bit   = bus.ena & bus.iMsg_flag & ~bus.iKey_flag & (r_key_state == KEY_READY);
    assign w_word_done = w_msg_bit & (r_msg_cnt == MW'(MSG_SIZE - 1));
    assign w_cipher    = {r_msg[MSG_SIZE-2:0], bus.iData_in} ^ w_slices[r_idx];
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_key_state <= KEY_EMPTY;
            r_key       <= '0;
            r_key_cnt   <= '0;
            r_msg       <= '0;
            r_msg_cnt   <= '0;
            r_idx       <= '0;
            r_err       <= 1'b0;
        end else if (bus.ena) begin
            if (bus.iKey_flag) begin
                r_key <= {r_key[KEY_SIZE-2:0], bus.iData_in};
                r_err <= bus.iMsg_flag;
                if (r_key_cnt == KW'(KEY_SIZE - 1)) begin
                    r_key_state <= KEY_READY;
                    r_key_cnt   <= '0;
                    r_idx       <= '0;
                end else begin
                    r_key_state <= KEY_LOADING;
                    r_key_cnt   <= r_key_cnt + 1'b1;
                end
            end else if (r_key_state == KEY_LOADING) begin
                r_key_state <= KEY_EMPTY;
                r_key_cnt   <= '0;
            end
            if (bus.iMsg_flag && !bus.iKey_flag && r_key_state != KEY_READY)
                r_err <= 1'b1;
            if (w_msg_bit)
                r_msg <= {r_msg[MSG_SIZE-2:0], bus.iData_in};
            r_msg_cnt <= (w_msg_bit && !w_word_done) ? r_msg_cnt + 1'b1 : '0;
            if (w_word_done && KEY_ROTATE != 0)
                r_idx <= (r_idx == IW'(NSLICE - 1)) ? '0 : r_idx + 1'b1;
        end
    end
    cipher_tx_shifter #(.MSG_SIZE(MSG_SIZE)) u_tx (
        .clk    (clk),
        .rst    (rst),
        .i_ena  (bus.ena),
        .i_load (w_word_done),
        .i_word (w_cipher),
        .o_data (bus.oData_out),
        .o_flag (w_flag)
    );
    assign bus.oData_flag = w_flag;
    assign bus.oKey_valid = r_key_state == KEY_READY;
    assign bus.oError     = r_err;
    assign bus.oBusy      = (r_msg_cnt != '0) | w_flag;
endmodule

// File: tb/tb_xor_stream_cipher.sv
// tb_xor_stream_cipher: directed vectors against a rotating and a fixed-slice instance
module tb_xor_stream_cipher;
    localparam logic [31:0] KEY = 32'hA5C30F96;
    logic clk = 1'b0;
    logic rst, ena, d, kf, mf;
    int   n_cmp = 0;
    int   n_bad = 0;
    always #5 clk = ~clk;

    xor_stream_cipher_if bus_r ();
    xor_stream_cipher_if bus_n ();
    assign bus_r.ena = ena;
    assign bus_r.iData_in = d;
    assign bus_r.iKey_flag = kf;
    assign bus_r.iMsg_flag = mf;
    assign bus_n.ena = ena;
    assign bus_n.iData_in = d;
    assign bus_n.iKey_flag = kf;
    assign bus_n.iMsg_flag = mf;

    xor_stream_cipher #(.MSG_SIZE(8), .KEY_SIZE(32), .KEY_ROTATE(1)) dut_r (.clk(clk), .rst(rst), .bus(bus_r));
    xor_stream_cipher #(.MSG_SIZE(8), .KEY_SIZE(32), .KEY_ROTATE(0)) dut_n (.clk(clk), .rst(rst), .bus(bus_n));

    // Collect ciphertext words; ena-low cycles repeat the same bit and are skipped
    logic [7:0] sh_r, sh_n;
    int nb_r = 0, nb_n = 0, run = 0;
    logic [7:0] q_r[$];
    logic [7:0] q_n[$];
    int runs[$];
    always @(negedge clk) begin
        if (rst) begin
            nb_r = 0;
            nb_n = 0;
            run = 0;
        end else if (ena) begin
            if (bus_r.oData_flag) begin
                sh_r = {sh_r[6:0], bus_r.oData_out};
                nb_r++;
                run++;
                if (nb_r == 8) begin
                    q_r.push_back(sh_r);
                    nb_r = 0;
                end
            end else if (run > 0) begin
                runs.push_back(run);
                run = 0;
            end
            if (bus_n.oData_flag) begin
                sh_n = {sh_n[6:0], bus_n.oData_out};
                nb_n++;
                if (nb_n == 8) begin
                    q_n.push_back(sh_n);
                    nb_n = 0;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [63:0] v, input int n, input logic k, input logic m);
        for (int i = n - 1; i >= 0; i--) begin
            d = v[i];
            kf = k;
            mf = m;
            ena = 1'b1;
            step();
        end
    endtask

    task automatic idle(input int n);
        kf = 1'b0;
        mf = 1'b0;
        ena = 1'b1;
        repeat (n) step();
    endtask

    task automatic clr();
        q_r.delete();
        q_n.delete();
        runs.delete();
    endtask

    typedef struct {
        logic       reload;
        logic [7:0] msg;
        logic [7:0] exp_r;
        logic [7:0] exp_n;
    } vec_t;
    vec_t tv[8];

    initial begin
        tv[0] = '{1'b1, 8'h3C, 8'h99, 8'h99};
        tv[1] = '{1'b0, 8'h3C, 8'hFF, 8'h99};
        tv[2] = '{1'b0, 8'h3C, 8'h33, 8'h99};
        tv[3] = '{1'b0, 8'h3C, 8'hAA, 8'h99};
        tv[4] = '{1'b0, 8'h3C, 8'h99, 8'h99};
        tv[5] = '{1'b0, 8'h3C, 8'hFF, 8'h99};
        tv[6] = '{1'b1, 8'h00, 8'hA5, 8'hA5};
        tv[7] = '{1'b0, 8'hFF, 8'h3C, 8'h5A};
        rst = 1'b1;
        ena = 1'b0;
        d = 1'b0;
        kf = 1'b0;
        mf = 1'b0;
        repeat (2) step();
        chk("rst_flag", bus_r.oData_flag, 0);
        chk("rst_out", bus_r.oData_out, 0);
        chk("rst_keyvalid", bus_r.oKey_valid, 0);
        chk("rst_busy", bus_r.oBusy, 0);
        chk("rst_error", bus_r.oError, 0);
        rst = 1'b0;

        // Single word: latency and bit order
        send(KEY, 32, 1, 0);
        idle(1);
        chk("t1_keyvalid", bus_r.oKey_valid, 1);
        chk("t1_error", bus_r.oError, 0);
        send(64'h1E, 7, 0, 1);
        chk("t1_flag_before", bus_r.oData_flag, 0);
        chk("t1_busy_mid", bus_r.oBusy, 1);
        send(64'h0, 1, 0, 1);
        chk("t1_flag_first", bus_r.oData_flag, 1);
        chk("t1_msb", bus_r.oData_out, 1);
        idle(10);
        chk("t1_nwords", q_r.size(), 1);
        chk("t1_word", q_r[0], 8'h99);
        chk("t1_run", runs[0], 8);
        clr();

        // Back-to-back stream with slice wrap, then key reload and fixed-slice comparison
        for (int i = 0; i < 8; i++) begin
            if (tv[i].reload) begin
                idle(1);
                send(KEY, 32, 1, 0);
                idle(1);
            end
            send(64'(tv[i].msg), 8, 0, 1);
        end
        idle(12);
        chk("tbl_nwords_r", q_r.size(), 8);
        chk("tbl_nwords_n", q_n.size(), 8);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("tbl_rot_%0d", i), q_r[i], tv[i].exp_r);
            chk($sformatf("tbl_fix_%0d", i), q_n[i], tv[i].exp_n);
        end
        chk("tbl_nruns", runs.size(), 2);
        chk("tbl_run_stream", runs[0], 48);
        chk("tbl_run_pair", runs[1], 16);

        // Message before key, then key load clears the error
        rst = 1'b1;
        step();
        rst = 1'b0;
        clr();
        send(64'h3C, 8, 0, 1);
        idle(1);
        chk("nokey_error", bus_r.oError, 1);
        chk("nokey_keyvalid", bus_r.oKey_valid, 0);
        idle(10);
        chk("nokey_nwords", q_r.size(), 0);
        chk("nokey_busy", bus_r.oBusy, 0);
        send(KEY, 32, 1, 0);
        idle(1);
        chk("reload_error", bus_r.oError, 0);
        chk("reload_keyvalid", bus_r.oKey_valid, 1);

        // Partial word leaves the slice index alone
        send(64'h16, 5, 0, 1);
        idle(1);
        chk("partial_busy", bus_r.oBusy, 0);
        send(64'h00, 8, 0, 1);
        idle(10);
        chk("partial_nwords", q_r.size(), 1);
        chk("partial_word", q_r[0], 8'hA5);

        // Key and message flags together
        d = 1'b1;
        kf = 1'b1;
        mf = 1'b1;
        ena = 1'b1;
        step();
        chk("both_error", bus_r.oError, 1);
        chk("both_keyvalid", bus_r.oKey_valid, 0);
        idle(1);
        chk("both_sticky", bus_r.oError, 1);

        // Asynchronous reset during transmission
        clr();
        send(KEY, 32, 1, 0);
        idle(1);
        send(64'h3C, 8, 0, 1);
        idle(3);
        #2 rst = 1'b1;
        #1;
        chk("arst_flag", bus_r.oData_flag, 0);
        chk("arst_keyvalid", bus_r.oKey_valid, 0);
        chk("arst_out", bus_r.oData_out, 0);
        step();
        rst = 1'b0;
        idle(2);
        chk("arst_nwords", q_r.size(), 0);

        // ena low mid-word on input and on output
        clr();
        send(KEY, 32, 1, 0);
        idle(1);
        send(64'h3, 4, 0, 1);
        ena = 1'b0;
        for (int i = 0; i < 4; i++) begin
            d = ~d;
            step();
        end
        chk("ena_in_busy", bus_r.oBusy, 1);
        chk("ena_in_flag", bus_r.oData_flag, 0);
        send(64'hC, 4, 0, 1);
        idle(3);
        ena = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("ena_hold_flag_%0d", i), bus_r.oData_flag, 1);
            chk($sformatf("ena_hold_bit_%0d", i), bus_r.oData_out, 1);
        end
        idle(10);
        chk("ena_nwords", q_r.size(), 1);
        chk("ena_word", q_r[0], 8'h99);
        chk("ena_run", runs[0], 8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/xor_stream_cipher.md
# xor_stream_cipher

Parametrised serial XOR stream-cipher engine and successor to the single-word key/message/XOR/serializer chain. A key of KEY_SIZE bits and an unbounded stream of MSG_SIZE-bit message words arrive on one shared serial input. Each completed word is XORed with a key slice that advances word by word and wraps around the key. Ciphertext leaves on a serial output with a data-valid flag. The block sits between the tile's pin wrapper and the capture interface, and supports back-to-back words with no gap cycles.

## Interface
- MSG_SIZE, 8, bits per message/ciphertext word (≥2)
- KEY_SIZE, 32, key bits; must be an integer multiple of MSG_SIZE
- KEY_ROTATE, 1, 1: key slice advances per word; 0: slice 0 used for every word
- clk  input  1  clock, all state on rising edge
- rst  input  1  reset, asynchronous, active-high
- ena  input  1  global enable; low freezes all state, outputs hold
- iData_in  input  1  shared serial data, MSB first
- iKey_flag  input  1  high while key bits are presented
- iMsg_flag  input  1  high while message bits are presented
- oData_out  output  1  serial ciphertext, MSB first
- oData_flag  output  1  high while oData_out carries a valid ciphertext bit
- oKey_valid  output  1  full key loaded
- oBusy  output  1  word in assembly or in transmission
- oError  output  1  sticky protocol error

## Operation
- Reset: all registers cleared. oData_out=0, oData_flag=0, oKey_valid=0, oBusy=0, oError=0. Key slice index is 0.
- Key FSM states are KEY_EMPTY, KEY_LOADING and KEY_READY.
  - A cycle with iKey_flag=1 and ena=1 shifts iData_in into the key register. It also clears oKey_valid and oError and enters KEY_LOADING.
  - On the KEY_SIZE-th bit the FSM enters KEY_READY, sets oKey_valid=1 and resets the slice index to 0.
  - If iKey_flag drops early, the partial key is discarded: the FSM returns to KEY_EMPTY and the bit counter is cleared.
- Message assembly runs only in KEY_READY.
  - A cycle with iMsg_flag=1 and ena=1 shifts one bit into the message register.
  - On the MSG_SIZE-th bit, the ciphertext is message ^ slice[idx]. slice[i] is the key bits received i*MSG_SIZE .. i*MSG_SIZE+MSG_SIZE-1 (first-received bit is the MSB).
  - After each word, idx increments and wraps from KEY_SIZE/MSG_SIZE-1 to 0. With KEY_ROTATE=0, idx stays 0.
  - If iMsg_flag drops mid-word, the partial word is discarded: the counter is cleared, idx is unchanged and no output is produced.
- Error conditions, which set oError and ignore the bit:
  - iMsg_flag=1 while not in KEY_READY.
  - iKey_flag=1 and iMsg_flag=1 in the same cycle. Key load takes priority: the bit goes to the key and the partial message is discarded.
- Transmit FSM states are TX_IDLE and TX_SHIFT.
  - A completed ciphertext word loads the output shift register and enters TX_SHIFT.
  - oData_flag=1 for exactly MSG_SIZE cycles, with oData_out equal to the register MSB. The register shifts left each enabled cycle.
  - If a new word completes on the same edge as the last bit's cycle ends, the reload wins and the flag stays high. This gives continuous streaming.
- A key reload during TX_SHIFT does not alter the in-flight ciphertext word.
- oBusy = (message bit count ≠ 0) | oData_flag.

## Timing
- Latency: the last message bit is sampled at edge N. Ciphertext MSB appears on oData_out with oData_flag=1 in the cycle after edge N, and the LSB appears after edge N+MSG_SIZE-1.
- Throughput: one word per MSG_SIZE enabled cycles, sustained indefinitely.
- Key ready: oKey_valid rises in the cycle after the edge sampling the KEY_SIZE-th key bit. A message bit is accepted starting the following cycle.
- ena=0: no counter, register, FSM or flag changes. ena is not treated as an abort.
- rst asserted mid-operation: outputs go to reset values immediately (asynchronous). The in-flight word is lost and the key is invalid.

## Structure
- Package xor_cipher_pkg holds:
  - the key_state_t enum (KEY_EMPTY/KEY_LOADING/KEY_READY) and the tx_state_t enum (TX_IDLE/TX_SHIFT);
  - the default MSG_SIZE/KEY_SIZE constants;
  - the function deriving the slice count and index width ($clog2(KEY_SIZE/MSG_SIZE), minimum 1).
- One sub-module, cipher_tx_shifter: parallel-load/serial-out register with load, shift, flag and MSG_SIZE-cycle counter.
- Key/message shift-in and slice mux stay in the top.
- Elaboration-time check: KEY_SIZE % MSG_SIZE == 0.

## Test plan
- Defaults, key 0xA5C30F96 then word 0x3C → serial 0x99 (10011001) with oData_flag high for 8 cycles, starting the cycle after the last message bit.
- Six back-to-back words of 0x3C with no gaps → 0x99, 0xFF, 0x33, 0xAA, 0x99, 0xFF. oData_flag is continuous for 48 cycles and the wrap after slice 3 is visible.
- KEY_ROTATE=0, same key, words 0x00, 0xFF → 0xA5, 0x5A.
- Message bits before any key → oError=1, no output. Then a full key load → oError=0, oKey_valid=1.
- 5 bits of a word, then iMsg_flag low, then word 0x00 → 0xA5 (idx unchanged by the partial word). Also iKey_flag and iMsg_flag both high → oError=1.
- rst pulse at bit 3 of transmission → oData_flag and oKey_valid drop immediately. ena low for 4 cycles mid-word → output stretched, bits intact.
